cycle_timer: RTL and testbench
==============================

CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 Parameter DIV, default 25_000_000: clk cycles per phase advance in run mode (legal 2..2^26).
REQ-002 Parameter DEB, default 500_000: clk cycles the synchronised step level must be stable before a change is accepted (legal >= 2).
REQ-003 clk  in  1  50 MHz system clock; the only clock.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 run  in  1  synchronous level; 1 = free-run at DIV rate, 0 = single-step mode.
REQ-006 step_btn  in  1  raw pushbutton, asynchronous, active-high when pressed.
REQ-007 halt_req  in  1  synchronous level from the CPU; requests stop at the end of the current EXECUTE cycle.
REQ-008 FETCH  out  1  major cycle is FETCH.
REQ-009 EXECUTE  out  1  major cycle is EXECUTE.
REQ-010 T  out  4  one-hot phase T[0]..T[3]; T[0] drives the CPU T0 input, T[1] drives T1.
REQ-011 tick  out  1  one-clk strobe in the cycle a phase advance is committed.
REQ-012 halted  out  1  timer is in HALTED.

Function
REQ-013 State machine states: FETCH, EXECUTE, HALTED; 2-bit phase counter 0..3 valid in FETCH/EXECUTE.
REQ-014 Outputs are registered: FETCH/EXECUTE/halted decode the state; T = 1<<phase outside HALTED, 4'b0000 in HALTED.
REQ-015 Advance event: in run mode, prescaler reaching DIV-1; in step mode, one accepted press.
REQ-016 On advance with phase<3: phase+1, major state unchanged.
REQ-017 On advance with phase==3: phase->0; FETCH->EXECUTE; EXECUTE->FETCH if halt_req==0, else EXECUTE->HALTED.
REQ-018 halt_req is sampled only in the clk of the EXECUTE T3 advance; assertion at other times has no effect.
REQ-019 tick is 1 in exactly the clk following each advance event, coincident with the new T value, and never in HALTED.
REQ-020 Prescaler counts 0..DIV-1 while run==1 and state!=HALTED, wraps to 0 on the advance; held at 0 while run==0.
REQ-021 run 1->0 mid-count: prescaler clears next clk, phase holds; run 0->1: first advance occurs DIV clks later.
REQ-022 step_btn passes a 2-flop synchroniser, then a DEB-cycle stability filter; a press is the filtered level's 0->1 edge, one advance per press regardless of hold time.
REQ-023 Press accepted while run==1 is discarded (no advance, not queued).
REQ-024 Prescaler wrap and press in the same clk: exactly one advance.
REQ-025 HALTED is sticky: run, step_btn and halt_req are ignored; exit only by reset.

Reset
REQ-026 rst_n low asynchronously forces: state FETCH, phase 0, T=4'b0001, FETCH=1, EXECUTE=0, tick=0, halted=0, prescaler 0, synchroniser and filter to 0 (released).
REQ-027 Reset mid-cycle or in HALTED aborts without completing the phase; a step press held through reset release does not produce an advance.
REQ-028 Deassertion is consumed on the clk edge; the first advance cannot occur before DIV clks (run) or DEB+3 clks (step) after release.

Structure
REQ-029 Shared package nicnac_pkg holds the major-state encoding (FETCH/EXECUTE/HALTED) and phase index constants T0..T3.
REQ-030 One sub-module step_sync: synchroniser, DEB stability filter, rising-edge pulse; parameter DEB; ports clk, rst_n, btn, press.
REQ-031 Prescaler, state machine and output registers live in cycle_timer; no other clocks or gated clocks.

Verification (DIV=4, DEB=3)
REQ-032 Reset release, run=1, halt_req=0 -> T sequence 0001,0010,0100,1000 with FETCH=1, then same with EXECUTE=1; each phase lasts 4 clks, tick once per phase.
REQ-033 run=0, step_btn pulsed 3 times (each held 10 clks, released 10 clks) -> exactly 3 advances, T ends at 1000, FETCH=1.
REQ-034 step_btn bounces 1 clk high/low for 6 clks then holds high 10 clks -> exactly one advance.
REQ-035 run=1, halt_req=1 asserted during EXECUTE T1, held -> EXECUTE T3 completes, then halted=1, T=0000, FETCH=EXECUTE=0, no further tick under run or step.
REQ-036 run=1, rst_n low during EXECUTE T2 for 2 clks -> outputs return to REQ-026 values immediately; first tick 4 clks after release.
REQ-037 run toggled 1->0 at prescaler count 2, step press, run 0->1 -> one advance from press, then next advance exactly 4 clks after run rises.

Source files
------------

// File: rtl/nicnac_pkg.sv
// Shared definitions for the NICNAC cycle timer.
//   major_state_t : major-cycle encoding (FETCH / EXECUTE / HALTED)
//   T0..T3        : phase index constants for the 2-bit phase counter
//   phase_onehot  : phase index -> one-hot T vector
package nicnac_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_HALTED  = 2'b10
    } major_state_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    function automatic logic [3:0] phase_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/step_sync.sv
// Pushbutton conditioner for single-step mode.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous pushbutton, active-high
//   press : one-clk pulse on each accepted press (filtered 0->1 edge)
// The raw level passes a 2-flop synchroniser, then must hold a new value
// for DEB consecutive clks before the filtered level follows it.
module step_sync #(
    parameter int DEB = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic [CW-1:0] cnt;
    logic [1:0]    primed;
    logic          armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
            primed <= 2'b00;
            armed  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            // primed[1] marks that sync2 now carries a real sample rather
            // than its reset value. Presses count only once the button has
            // been seen released after reset, so a button held through
            // reset release never produces a step.
            primed <= {primed[0], 1'b1};
            if (primed[1] && !sync2)
                armed <= 1'b1;

            press <= 1'b0;
            if (sync2 != filt) begin
                if (cnt == CW'(DEB - 1)) begin
                    filt  <= sync2;
                    cnt   <= '0;
                    press <= sync2 & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cycle_timer.sv
// NICNAC major-cycle / phase timer.
//   clk       : 50 MHz system clock
//   rst_n     : asynchronous active-low reset
//   run       : 1 = free-run, advancing every DIV clks; 0 = single-step
//   step_btn  : raw pushbutton, one phase advance per press in step mode
//   halt_req  : sampled only at the EXECUTE T3 advance; 1 = stop
//   FETCH     : major cycle is FETCH
//   EXECUTE   : major cycle is EXECUTE
//   T         : one-hot phase (0000 while halted)
//   tick      : one-clk strobe coincident with each new T value
//   halted    : timer is in HALTED (sticky until reset)
//   state_dbg : current major state, for observation only
module cycle_timer
    import nicnac_pkg::*;
#(
    parameter int DIV = 25_000_000,
    parameter int DEB = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         step_btn,
    input  logic         halt_req,
    output logic         FETCH,
    output logic         EXECUTE,
    output logic [3:0]   T,
    output logic         tick,
    output logic         halted,
    output major_state_t state_dbg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          press;
    logic          adv;
    major_state_t  state;
    logic [1:0]    phase;

    step_sync #(.DEB(DEB)) u_step_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step_btn),
        .press (press)
    );

    assign presc_wrap = (presc == PW'(DIV - 1));
    // run selects the advance source, so a press during run is dropped and
    // a wrap coinciding with a press still yields a single advance.
    assign adv       = (state != ST_HALTED) && (run ? presc_wrap : press);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (!run || state == ST_HALTED || presc_wrap)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            phase   <= T0;
            FETCH   <= 1'b1;
            EXECUTE <= 1'b0;
            T       <= 4'b0001;
            tick    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (adv) begin
                if (phase != T3) begin
                    phase <= phase + 2'd1;
                    T     <= phase_onehot(phase + 2'd1);
                    tick  <= 1'b1;
                end else begin
                    phase <= T0;
                    case (state)
                        ST_FETCH: begin
                            state   <= ST_EXECUTE;
                            FETCH   <= 1'b0;
                            EXECUTE <= 1'b1;
                            T       <= phase_onehot(T0);
                            tick    <= 1'b1;
                        end
                        ST_EXECUTE: begin
                            if (halt_req) begin
                                // Entering HALTED: no tick, T blanked.
                                state   <= ST_HALTED;
                                EXECUTE <= 1'b0;
                                halted  <= 1'b1;
                                T       <= 4'b0000;
                            end else begin
                                state   <= ST_FETCH;
                                FETCH   <= 1'b1;
                                EXECUTE <= 1'b0;
                                T       <= phase_onehot(T0);
                                tick    <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cycle_timer.sv
// Bench for cycle_timer with DIV=4, DEB=3.
module tb_cycle_timer;
    import nicnac_pkg::*;

    localparam int DIV_P = 4;
    localparam int DEB_P = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic run_i, btn_i, halt_i;
    logic fetch_o, execute_o, tick_o, halted_o;
    logic [3:0] t_o;
    major_state_t dbg_state;

    always #5 clk = ~clk;

    cycle_timer #(.DIV(DIV_P), .DEB(DEB_P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run_i),
        .step_btn  (btn_i),
        .halt_req  (halt_i),
        .FETCH     (fetch_o),
        .EXECUTE   (execute_o),
        .T         (t_o),
        .tick      (tick_o),
        .halted    (halted_o),
        .state_dbg (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // {FETCH, EXECUTE, halted, tick, T}
    function automatic logic [7:0] outs();
        return {fetch_o, execute_o, halted_o, tick_o, t_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Position in the 8-phase major cycle (0..3 FETCH, 4..7 EXECUTE);
    // button debouncing judged from a history of sampled levels.
    int   m_pos;
    bit   m_halted;
    int   m_cnt;
    bit   m_filt, m_press, m_tick, m_adv, m_same;
    bit   hist[$];
    int   sz;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pos = 0; m_halted = 0; m_cnt = 0;
                m_filt = 0; m_press = 0; m_tick = 0;
                hist.delete();
                for (int i = 0; i < DEB_P + 2; i++) hist.push_back(1'b0);
            end else begin
                m_adv = 0;
                if (!m_halted) begin
                    if (run_i) begin
                        if (m_cnt == DIV_P - 1) begin m_adv = 1; m_cnt = 0; end
                        else m_cnt++;
                    end else begin
                        m_cnt = 0;
                        m_adv = m_press;
                    end
                end else begin
                    m_cnt = 0;
                end
                // Synchronised level seen now is the button two clks ago.
                sz = hist.size();
                m_same = 1;
                for (int i = 0; i < DEB_P; i++)
                    if (hist[sz-2-i] != hist[sz-2]) m_same = 0;
                if (m_same && hist[sz-2] != m_filt) begin
                    m_filt  = hist[sz-2];
                    m_press = m_filt;
                end else begin
                    m_press = 0;
                end
                hist.push_back(btn_i);
                if (hist.size() > 32) void'(hist.pop_front());
                m_tick = m_adv && !(m_pos == 7 && halt_i);
                if (m_adv) begin
                    if (m_pos == 7) begin
                        if (halt_i) m_halted = 1;
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] model_outs();
        logic [3:0] t;
        if (m_halted) return 8'b0010_0000;
        t = 4'b0001 << (m_pos % 4);
        return {(m_pos < 4), (m_pos >= 4), 1'b0, m_tick, t};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", outs(), 8'b1000_0001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic count_ticks(input int n, inout int ticks);
        repeat (n) begin
            @(negedge clk);
            if (tick_o) ticks++;
        end
    endtask

    task automatic wait_phase(input logic e, input logic [3:0] t, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (execute_o == e && t_o == t) ok = 1;
        end
    endtask

    task automatic edges_to_tick(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget && n == 0; i++) begin
            @(negedge clk);
            if (tick_o) n = i;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       run;
        int         clks;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   ticks, n;
    bit   ok;

    initial begin
        rst_n = 1'b0; run_i = 1'b0; btn_i = 1'b0; halt_i = 1'b0;

        // Free-run sequence from reset, then hold and resume.
        vecs = '{
            '{1'b1, 0, 8'b1000_0001},
            '{1'b1, 3, 8'b1000_0001}, '{1'b1, 1, 8'b1001_0010},
            '{1'b1, 3, 8'b1000_0010}, '{1'b1, 1, 8'b1001_0100},
            '{1'b1, 3, 8'b1000_0100}, '{1'b1, 1, 8'b1001_1000},
            '{1'b1, 3, 8'b1000_1000}, '{1'b1, 1, 8'b0101_0001},
            '{1'b1, 3, 8'b0100_0001}, '{1'b1, 1, 8'b0101_0010},
            '{1'b1, 3, 8'b0100_0010}, '{1'b1, 1, 8'b0101_0100},
            '{1'b1, 3, 8'b0100_0100}, '{1'b1, 1, 8'b0101_1000},
            '{1'b1, 3, 8'b0100_1000}, '{1'b1, 1, 8'b1001_0001},
            '{1'b0, 6, 8'b1000_0001},
            '{1'b1, 3, 8'b1000_0001}, '{1'b1, 1, 8'b1001_0010}
        };

        @(negedge clk);
        run_i = 1'b1;
        do_reset();
        foreach (vecs[i]) begin
            run_i = vecs[i].run;
            repeat (vecs[i].clks) @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Three clean step presses.
        run_i = 1'b0; btn_i = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        ticks = 0;
        repeat (3) begin
            btn_i = 1'b1; count_ticks(10, ticks);
            btn_i = 1'b0; count_ticks(10, ticks);
        end
        check("step3_ticks", ticks, 3);
        check("step3_outs", outs(), 8'b1000_1000);

        // Bouncing press gives a single advance.
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            btn_i = (i % 2 == 0);
            count_ticks(1, ticks);
        end
        btn_i = 1'b1; count_ticks(10, ticks);
        btn_i = 1'b0; count_ticks(10, ticks);
        check("bounce_ticks", ticks, 1);
        check("bounce_outs", outs(), 8'b0100_0001);

        // Button held through reset release is ignored; a later press counts.
        btn_i = 1'b1;
        do_reset();
        ticks = 0;
        count_ticks(20, ticks);
        check("held_rst_ticks", ticks, 0);
        btn_i = 1'b0; count_ticks(10, ticks);
        btn_i = 1'b1; count_ticks(10, ticks);
        btn_i = 1'b0; count_ticks(5, ticks);
        check("after_held_ticks", ticks, 1);
        check("after_held_outs", outs(), 8'b1000_0010);

        // run dropped mid-count, step press, run restored.
        run_i = 1'b1; btn_i = 1'b0;
        do_reset();
        repeat (2) @(negedge clk);
        run_i = 1'b0;
        ticks = 0;
        btn_i = 1'b1; count_ticks(10, ticks);
        btn_i = 1'b0; count_ticks(10, ticks);
        check("runtoggle_ticks", ticks, 1);
        check("runtoggle_outs", outs(), 8'b1000_0010);
        run_i = 1'b1;
        edges_to_tick(12, n);
        check("runtoggle_resume", n, 4);

        // halt_req outside EXECUTE T3 has no effect.
        do_reset();
        wait_phase(1'b0, 4'b1000, 40, ok);
        check("reach_fetch_t3", ok, 1);
        halt_i = 1'b1;
        repeat (4) @(negedge clk);
        halt_i = 1'b0;
        repeat (16) @(negedge clk);
        check("halt_ignored", outs(), 8'b1001_0001);

        // Halt requested during EXECUTE T1.
        do_reset();
        wait_phase(1'b1, 4'b0010, 40, ok);
        check("reach_exec_t1", ok, 1);
        halt_i = 1'b1;
        ticks = 0;
        count_ticks(14, ticks);
        check("halt_ticks", ticks, 2);
        check("halt_outs", outs(), 8'b0010_0000);
        check("halt_state", dbg_state, ST_HALTED);
        halt_i = 1'b0;
        ticks = 0;
        count_ticks(20, ticks);
        run_i = 1'b0;
        btn_i = 1'b1; count_ticks(10, ticks);
        btn_i = 1'b0; count_ticks(10, ticks);
        check("halted_sticky_ticks", ticks, 0);
        check("halted_sticky_outs", outs(), 8'b0010_0000);

        // Reset during EXECUTE T2.
        run_i = 1'b1;
        do_reset();
        wait_phase(1'b1, 4'b0100, 40, ok);
        check("reach_exec_t2", ok, 1);
        do_reset();
        edges_to_tick(12, n);
        check("rst_first_tick", n, 4);

        // Randomised segments against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            btn_i = 1'b0; halt_i = 1'b0;
            run_i = 1'($urandom_range(0, 1));
            do_reset();
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                check("rand", outs(), model_outs());
                if ($urandom_range(0, 24) == 0) run_i = ~run_i;
                halt_i = ($urandom_range(0, 29) == 0);
                if (i >= 3 && $urandom_range(0, 4) == 0) btn_i = ~btn_i;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
